// File: rtl/capture_fifo_pkg.sv
// -----------------------------------------------------------------------------
// capture_fifo_pkg
// Shared definitions for the capture FIFO: mode constants, the write-action
// encoding and the helpers that size pointers and pick a write action.
// -----------------------------------------------------------------------------
package capture_fifo_pkg;

    localparam int MODE_STOP = 0;   // drop new writes while full
    localparam int MODE_WRAP = 1;   // overwrite the oldest entry while full

    typedef enum logic [1:0] {
        WR_NONE,        // no strobe edge this cycle
        WR_ACCEPT,      // normal write, occupancy may grow
        WR_DROP,        // full in stop mode: write discarded
        WR_OVERWRITE    // full in wrap mode: oldest entry replaced
    } wr_action_e;

    // Address width for a buffer of 'depth' entries.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // A full buffer can still take a write when a read frees a slot in the
    // same cycle; only otherwise does the mode matter.
    function automatic wr_action_e wr_decide(input logic wr_edge,
                                             input logic is_full,
                                             input logic rd_ok,
                                             input logic wrap);
        if (!wr_edge)
            return WR_NONE;
        else if (!is_full || rd_ok)
            return WR_ACCEPT;
        else if (wrap)
            return WR_OVERWRITE;
        else
            return WR_DROP;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// -----------------------------------------------------------------------------
// rise_edge_detect
// Registers the previous value of a level signal and flags its 0->1 change.
// The previous value resets to 0, so a signal already high when reset is
// released yields one edge on the first clock afterwards.
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   i_sig  : level input
//   o_edge : high while i_sig is 1 and was 0 on the previous clock
// -----------------------------------------------------------------------------
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_prev;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prev <= 1'b0;
        else
            r_prev <= i_sig;
    end

    assign o_edge = i_sig & ~r_prev;

endmodule

// File: rtl/capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
// Circular capture buffer fed by a level strobe. Each rising edge of
// wr_strobe stores wr_data; a consumer drains entries in order with rd_en.
// When full, WRAP_MODE selects dropping new words or overwriting the oldest;
// either case sets the sticky overflow flag.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   wr_data   : word stored on a strobe edge
//   wr_strobe : level strobe, write requested on its 0->1 transition
//   rd_en     : read request, ignored while empty
//   clr_ovf   : synchronous clear of overflow (a new overflow wins)
//   rd_data   : registered read data
//   rd_valid  : one-cycle pulse, rd_data valid (one clock after rd_en)
//   last_data : most recently accepted write word
//   count     : occupancy 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, a write was dropped or overwrote data
// -----------------------------------------------------------------------------
module capture_fifo
    import capture_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int WRAP_MODE = MODE_STOP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_strobe,
    input  logic                      rd_en,
    input  logic                      clr_ovf,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         last_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_last_data;
    logic              r_overflow;

    logic              w_wr_edge;
    logic              w_rd_ok;
    logic              w_full;
    wr_action_e        w_wr_action;
    logic              w_do_write;
    logic              w_rd_adv;
    logic              w_ovf_event;
    logic [CW-1:0]     w_count_next;

    rise_edge_detect u_strobe_edge (
        .clk    (clk),
        .rst_n  (rst),
        .i_sig  (wr_strobe),
        .o_edge (w_wr_edge)
    );

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_rd_ok     = rd_en & (r_count != '0);
    assign w_wr_action = wr_decide(w_wr_edge, w_full, w_rd_ok,
                                   (WRAP_MODE == MODE_WRAP));
    assign w_do_write  = (w_wr_action == WR_ACCEPT) || (w_wr_action == WR_OVERWRITE);
    // Overwrite only happens without a read, so rd_ptr never double-advances.
    assign w_rd_adv    = w_rd_ok || (w_wr_action == WR_OVERWRITE);
    assign w_ovf_event = (w_wr_action == WR_DROP) || (w_wr_action == WR_OVERWRITE);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if ((w_wr_action == WR_ACCEPT) && !w_rd_ok)
            w_count_next = r_count + CW'(1);
        else if ((w_wr_action != WR_ACCEPT) && w_rd_ok)
            w_count_next = r_count - CW'(1);
    end

    // NOTE: the storage array has no reset; stale contents are unreachable
    // once the pointers and count are cleared, and a reset-free array maps
    // onto RAM.
    always_ff @(posedge clk) begin
        if (w_do_write)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_last_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_rd_valid <= w_rd_ok;
            if (w_do_write) begin
                r_wr_ptr    <= r_wr_ptr + AW'(1);
                r_last_data <= wr_data;
            end
            // When full, rd_ptr == wr_ptr; the read sees the old word because
            // the memory write lands at the same edge.
            if (w_rd_ok)
                r_rd_data <= r_mem[r_rd_ptr];
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_ovf_event)
                r_overflow <= 1'b1;
            else if (clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign last_data = r_last_data;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = (r_count == '0);
    assign overflow  = r_overflow;

endmodule
